// File: rtl/fnd_pkg.sv
// Shared constants for the 4-digit FND: segment polarity, bit order, hex font and scan states.
package fnd_pkg;

  localparam logic       SEG_ON     = 1'b0;
  localparam int         DP_BIT     = 7;
  localparam logic [7:0] FONT_BLANK = 8'hFF;
  localparam logic [3:0] DIGIT_OFF  = 4'hF;

  // Segment order {dp,g,f,e,d,c,b,a}, active low; entry 0 is the rightmost in this list.
  localparam logic [15:0][7:0] HEX_FONT = {
    8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
    8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GAP  = 2'd1,
    ST_SHOW = 2'd2
  } scan_state_t;

endpackage

// File: rtl/fnd_font_decoder.sv
// Nibble to active-low 8-segment glyph, with decimal point and whole-digit blanking.
module fnd_font_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  input  logic       blank,
  output logic [7:0] font
);

  always_comb begin
    font = blank ? FONT_BLANK : HEX_FONT[nibble];
    if (dp) font[DP_BIT] = SEG_ON;
  end

endmodule

// File: rtl/fnd_scan_controller.sv
// Autonomous 4-digit FND scanner with anti-ghost gap, leading-zero blanking and
// frame-synchronous display updates.
module fnd_scan_controller
  import fnd_pkg::*;
#(
  parameter int P_SCAN_DIV = 100000,
  parameter int P_GAP      = 16
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_load,
  input  logic        i_blank_lz,
  output logic [3:0]  o_FND_Digit,
  output logic [7:0]  o_FND_Font,
  output logic [1:0]  o_digit_idx,
  output logic        o_frame
);

  localparam int CW = (P_SCAN_DIV > 1) ? $clog2(P_SCAN_DIV) : 1;

  scan_state_t    state_reg, state_next;
  logic [CW-1:0]  cnt_reg;
  logic [1:0]     idx_reg;
  logic [15:0]    active_reg;
  logic [15:0]    pending_reg;
  logic           pend_flag_reg;

  logic           tick;
  logic           wrap;
  logic           sync;
  logic           lz_blank;
  logic [3:0]     nibble;
  logic [7:0]     dec_font;
  logic [3:0]     digit_next;
  logic [7:0]     font_next;
  logic           frame_next;

  assign tick = (state_reg == ST_SHOW) && (cnt_reg == CW'(P_SCAN_DIV - 1));
  assign wrap = tick && (idx_reg == 2'd3);
  // Active only changes at scan start or frame wrap so a frame never mixes two words.
  assign sync = i_en && (wrap || (state_reg == ST_IDLE));

  always_ff @(posedge i_clk) begin
    if (i_reset) state_reg <= ST_IDLE;
    else         state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (i_en) state_next = ST_GAP;
      ST_GAP:  if (cnt_reg == CW'(P_GAP - 1)) state_next = ST_SHOW;
      ST_SHOW: if (tick) state_next = ST_GAP;
      default: state_next = ST_IDLE;
    endcase
    if (!i_en) state_next = ST_IDLE;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_reg       <= '0;
      idx_reg       <= 2'd0;
      active_reg    <= 16'h0000;
      pending_reg   <= 16'h0000;
      pend_flag_reg <= 1'b0;
    end else begin
      if (!i_en || state_reg == ST_IDLE) begin
        cnt_reg <= '0;
        idx_reg <= 2'd0;
      end else if (tick) begin
        cnt_reg <= '0;
        idx_reg <= idx_reg + 2'd1;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
      end

      // A load arriving on the sync cycle itself bypasses pending straight into active.
      if (sync) begin
        if (i_load)             active_reg <= i_value;
        else if (pend_flag_reg) active_reg <= pending_reg;
        pend_flag_reg <= 1'b0;
      end else if (i_load) begin
        pend_flag_reg <= 1'b1;
      end

      if (i_load) pending_reg <= i_value;
    end
  end

  assign nibble   = active_reg[{idx_reg, 2'b00} +: 4];
  assign lz_blank = i_blank_lz && (idx_reg != 2'd0) &&
                    ((active_reg >> {idx_reg, 2'b00}) == 16'h0000);

  fnd_font_decoder u_font (
    .nibble (nibble),
    .dp     (i_dp[idx_reg]),
    .blank  (lz_blank),
    .font   (dec_font)
  );

  always_comb begin
    digit_next = DIGIT_OFF;
    font_next  = FONT_BLANK;
    frame_next = i_en && wrap;
    if (i_en && state_reg == ST_SHOW) begin
      digit_next = ~(4'b0001 << idx_reg);
      font_next  = dec_font;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_FND_Digit <= DIGIT_OFF;
      o_FND_Font  <= FONT_BLANK;
      o_digit_idx <= 2'd0;
      o_frame     <= 1'b0;
    end else begin
      o_FND_Digit <= digit_next;
      o_FND_Font  <= font_next;
      o_digit_idx <= idx_reg;
      o_frame     <= frame_next;
    end
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a time-based display model.
module tb_fnd_scan_controller;

  localparam int DIV = 8;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        reset, en, load, blz;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [3:0]  o_FND_Digit;
  logic [7:0]  o_FND_Font;
  logic [1:0]  o_digit_idx;
  logic        o_frame;

  always #5 clk = ~clk;

  fnd_scan_controller #(.P_SCAN_DIV(DIV), .P_GAP(GAP)) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_en        (en),
    .i_value     (value),
    .i_dp        (dp),
    .i_load      (load),
    .i_blank_lz  (blz),
    .o_FND_Digit (o_FND_Digit),
    .o_FND_Font  (o_FND_Font),
    .o_digit_idx (o_digit_idx),
    .o_frame     (o_frame)
  );

  logic [7:0]  hexf [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Model: running flag, cycles since scan start, displayed and pending words.
  bit          running;
  int          t;
  logic [15:0] act, pend;
  bit          pv;

  int          n_assert = 0, n_fail = 0;
  int          cyc = 0, last_frame = -1;
  logic [7:0]  lit_font [4];

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_font(input logic [15:0] a, input int s);
    logic [7:0] f;
    logic [15:0] upper;
    upper = a >> (4 * s);
    f = (blz && s > 0 && upper == 16'h0) ? 8'hFF : hexf[upper[3:0]];
    if (dp[s]) f[7] = 1'b0;
    return f;
  endfunction

  task automatic step();
    logic [3:0] e_dig;
    logic [7:0] e_font;
    logic       e_frame;
    logic [1:0] e_idx;
    int         slot, pos;
    bit         sync;
    slot = (t / DIV) % 4;
    pos  = t % DIV;
    @(posedge clk);
    e_dig = 4'hF; e_font = 8'hFF; e_frame = 1'b0; e_idx = 2'd0;
    if (!reset) begin
      if (running) e_idx = 2'(slot);
      if (en && running) begin
        if (pos >= GAP) begin
          e_dig  = ~(4'b0001 << slot);
          e_font = model_font(act, slot);
        end
        e_frame = (slot == 3) && (pos == DIV - 1);
      end
    end
    if (load) $display("load value=%h dp=%b cyc=%0d", value, dp, cyc);
    #1;
    chk("digit", 16'(o_FND_Digit), 16'(e_dig));
    chk("font",  16'(o_FND_Font),  16'(e_font));
    chk("frame", 16'(o_frame),     16'(e_frame));
    chk("idx",   16'(o_digit_idx), 16'(e_idx));
    if (o_FND_Digit != 4'hF) lit_font[o_digit_idx] = o_FND_Font;
    if (o_frame) begin
      if (last_frame >= 0) chk("frame_period", 16'(cyc - last_frame), 16'(4 * DIV));
      last_frame = cyc;
    end
    if (reset) begin
      running = 0; t = 0; act = 0; pend = 0; pv = 0; last_frame = -1;
    end else if (!en) begin
      running = 0; t = 0; last_frame = -1;
      if (load) begin pend = value; pv = 1; end
    end else begin
      sync = !running || (slot == 3 && pos == DIV - 1);
      if (running) t = (t + 1) % (4 * DIV);
      else begin running = 1; t = 0; end
      if (sync) begin
        if (load) begin act = value; pend = value; pv = 0; end
        else if (pv) begin act = pend; pv = 0; end
      end else if (load) begin
        pend = value; pv = 1;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic seek(input int s, input int p);
    bit found;
    found = 0;
    for (int i = 0; i < 8 * DIV && !found; i++) begin
      if (running && (t / DIV) % 4 == s && t % DIV == p) found = 1;
      else step();
    end
    chk("seek_reached", 16'(found), 16'd1);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    value = v; dp = d; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; load = 1'b0; blz = 1'b0; value = 16'h0; dp = 4'h0;
    running = 0; t = 0; act = 0; pend = 0; pv = 0;
    run(2);
    chk("rst_digit", 16'(o_FND_Digit), 16'h000F);
    chk("rst_font",  16'(o_FND_Font),  16'h00FF);
    reset = 1'b0;

    // Basic scan of 12AF
    do_load(16'h12AF, 4'h0);
    en = 1'b1;
    run(8 * DIV);
    chk("d0_F", 16'(lit_font[0]), 16'h008E);
    chk("d1_A", 16'(lit_font[1]), 16'h0088);
    chk("d2_2", 16'(lit_font[2]), 16'h00A4);
    chk("d3_1", 16'(lit_font[3]), 16'h00F9);

    // Leading-zero blanking
    blz = 1'b1;
    do_load(16'h0007, 4'h0);
    run(8 * DIV);
    chk("lz_d0", 16'(lit_font[0]), 16'h00F8);
    chk("lz_d1", 16'(lit_font[1]), 16'h00FF);
    chk("lz_d3", 16'(lit_font[3]), 16'h00FF);
    blz = 1'b0;
    run(4 * DIV);
    chk("nolz_d2", 16'(lit_font[2]), 16'h00C0);

    // Mid-frame load waits for the frame boundary
    seek(1, 4);
    do_load(16'h5555, 4'h0);
    seek(3, DIV - 1);
    chk("old_d2", 16'(lit_font[2]), 16'h00C0);
    chk("old_d3", 16'(lit_font[3]), 16'h00C0);
    run(4 * DIV);
    chk("new_d0", 16'(lit_font[0]), 16'h0092);

    // Load coincident with the wrap tick
    seek(3, DIV - 1);
    do_load(16'h000B, 4'h0);
    run(DIV);
    chk("bypass_d0", 16'(lit_font[0]), 16'h0083);

    // Decimal point on a blanked digit
    blz = 1'b1;
    do_load(16'h0000, 4'b0100);
    run(8 * DIV);
    chk("dp_d2", 16'(lit_font[2]), 16'h007F);
    chk("dp_d0", 16'(lit_font[0]), 16'h00C0);
    chk("dp_d1", 16'(lit_font[1]), 16'h00FF);

    // Enable drop and reset mid-scan
    seek(1, 4);
    en = 1'b0;
    step();
    chk("endrop_digit", 16'(o_FND_Digit), 16'h000F);
    chk("endrop_font",  16'(o_FND_Font),  16'h00FF);
    en = 1'b1;
    run(5 * DIV);
    seek(2, 5);
    reset = 1'b1;
    step();
    chk("midrst_digit", 16'(o_FND_Digit), 16'h000F);
    chk("midrst_frame", 16'(o_frame),     16'h0000);
    reset = 1'b0;
    run(4);
    chk("restart_idx",   16'(o_digit_idx), 16'h0000);
    chk("restart_digit", 16'(o_FND_Digit), 16'h000E);

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      load  = ($urandom_range(0, 7) == 0);
      value = 16'($urandom);
      if ($urandom_range(0, 3) == 0) dp = 4'($urandom);
      if ($urandom_range(0, 15) == 0) blz = ~blz;
      en    = ($urandom_range(0, 63) != 0);
      reset = ($urandom_range(0, 199) == 0);
      step();
    end
    load = 1'b0; reset = 1'b0; en = 1'b1;
    run(4 * DIV);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
